// File: rtl/weight_preloader.sv
// weight_preloader: fetches a run of beats from external weight memory over
// an in-order read request/response port and writes them into the weight
// buffer from address 0, then completes a four-phase preload handshake.
module weight_preloader #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 128,
  parameter int BUF_ADDR_W = 15,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  preload_req,
  input  logic [ADDR_W-1:0]     preload_base,
  input  logic [16:0]           preload_count,
  output logic                  preload_done,
  output logic                  mem_rd_req,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_rd_valid,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0]     buf_wdata,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << BUF_ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  written;
  logic [3:0]        outstanding;
  // Set once a request has been accepted since reset; responses still in
  // flight from before a reset must not be reported as stray.
  logic              armed;

  logic accept;
  logic rsp;
  logic stray;

  assign mem_rd_req  = (state == ISSUE) && (issued < count) && (outstanding < 4'(MAX_OUT));
  assign mem_rd_addr = base + ADDR_W'(issued);
  assign accept      = mem_rd_req && mem_rd_ready;
  assign rsp         = mem_rd_valid && (outstanding != '0);
  assign stray       = mem_rd_valid && (outstanding == '0) && armed;
  assign busy        = (state != IDLE);

  // Handshake FSM, request/response bookkeeping and registered buffer write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base         <= '0;
      count        <= '0;
      issued       <= '0;
      written      <= '0;
      outstanding  <= '0;
      armed        <= 1'b0;
      preload_done <= 1'b0;
      buf_we       <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= '0;
      err          <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      if (stray) err <= 1'b1;

      case ({accept, rsp})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase

      if (accept) issued <= issued + CNT_W'(1);

      if (rsp) begin
        buf_we    <= 1'b1;
        buf_addr  <= written[BUF_ADDR_W-1:0];
        buf_wdata <= mem_rd_data;
        written   <= written + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (preload_req) begin
            base        <= preload_base;
            issued      <= '0;
            written     <= '0;
            outstanding <= '0;
            armed       <= 1'b1;
            if (preload_count > DEPTH) begin
              count <= DEPTH;
              err   <= 1'b1;
            end else begin
              count <= preload_count;
              err   <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (count == '0)
            state <= DONE;
          else if (accept && (issued + CNT_W'(1) == count))
            state <= DRAIN;
        end
        DRAIN: begin
          if (rsp && (written + CNT_W'(1) == count))
            state <= DONE;
        end
        DONE: begin
          // First DONE cycle raises done; it then falls one cycle after req
          // is seen low, which also yields the one-cycle pulse when req was
          // already dropped during the transfer.
          if (!preload_done)
            preload_done <= 1'b1;
          else if (!preload_req) begin
            preload_done <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_preloader.sv
// Scoreboard bench for weight_preloader: a behavioural memory responder,
// expected read-address and buffer-write queues filled at request time, and
// a negedge monitor that pops and compares whenever the DUT acts.
module tb_weight_preloader;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 128;
  localparam int BUF_ADDR_W = 15;
  localparam int MAX_OUT    = 4;
  localparam int DEPTH      = 1 << BUF_ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  preload_req;
  logic [ADDR_W-1:0]     preload_base;
  logic [16:0]           preload_count;
  logic                  preload_done;
  logic                  mem_rd_req;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic                  mem_rd_ready;
  logic                  mem_rd_valid;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  buf_we;
  logic [BUF_ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0]     buf_wdata;
  logic                  busy;
  logic                  err;

  weight_preloader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_ADDR_W(BUF_ADDR_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .preload_req(preload_req), .preload_base(preload_base),
    .preload_count(preload_count), .preload_done(preload_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [BUF_ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { int due; logic [ADDR_W-1:0] a; } rsp_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_addr[$];
  rsp_t              rsp_q[$];

  int  cyc = 0, lat = 2, rdy_mode = 0, outst = 0, peak = 0, last_we = -1, we_cnt = 0;
  bit  hold_rsp = 0, spur = 0;
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;
  logic [31:0]       salt;

  // Contents of external memory as a function of beat address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return {x * 32'h9E3779B1, ~x, x ^ salt, salt + x};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor + memory responder: compares writes/reads, drives ready/valid.
  always @(negedge clk) begin
    logic acc;
    wr_t  w;
    rsp_t r;
    if (rst_n && buf_we) begin
      we_cnt++;
      last_we = cyc;
      if (exp_wr.size() == 0) chk("unexpected_write", buf_we, 1'b0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", buf_addr, w.a);
        chk("wr_data", buf_wdata, w.d);
      end
    end
    if (rst_n && mem_rd_req && stall_prev) chk("addr_hold", mem_rd_addr, addr_prev);

    case (rdy_mode)
      0:       mem_rd_ready = 1'b1;
      1:       mem_rd_ready = ~mem_rd_ready;
      default: mem_rd_ready = 1'($urandom_range(0, 1));
    endcase
    acc        = rst_n && mem_rd_req && mem_rd_ready;
    stall_prev = rst_n && mem_rd_req && !mem_rd_ready;
    addr_prev  = mem_rd_addr;
    if (acc) begin
      if (exp_addr.size() == 0) chk("unexpected_read", mem_rd_req, 1'b0);
      else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
      rsp_q.push_back('{cyc + lat, mem_rd_addr});
    end

    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    if (spur) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = {4{$urandom}};
      spur = 0;
    end else if (!hold_rsp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      mem_rd_valid = 1'b1;
      mem_rd_data  = mem_word(r.a);
      if (rst_n && outst > 0) outst--;
    end
    if (acc) outst++;
    if (outst > peak) peak = outst;
    cyc++;
  end

  task automatic push_expected(input logic [ADDR_W-1:0] base, input int eff);
    for (int i = 0; i < eff; i++) begin
      exp_addr.push_back(base + ADDR_W'(i));
      exp_wr.push_back('{BUF_ADDR_W'(i), mem_word(base + ADDR_W'(i))});
    end
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] base, input int cnt, input int l,
                          input int mode, input bit drop);
    int n, eff, k;
    eff = (cnt > DEPTH) ? DEPTH : cnt;
    lat = l; rdy_mode = mode; peak = 0; we_cnt = 0;
    push_expected(base, eff);
    preload_base = base; preload_count = 17'(cnt); preload_req = 1'b1;
    @(posedge clk); #2;
    chk("busy_after_accept", busy, 1'b1);
    chk("err_at_accept", err, cnt > DEPTH);
    preload_base  = ADDR_W'($urandom);
    preload_count = 17'($urandom);
    if (drop) preload_req = 1'b0;
    n = 1;
    while (!preload_done && n < 40000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_seen", preload_done, 1'b1);
    if (cnt == 0) chk("zero_done_latency", n, 3);
    else chk("done_after_last_write", cyc, last_we + 1);
    chk("write_count", we_cnt, eff);
    chk("reads_remaining", exp_addr.size(), 0);
    chk("peak_outstanding_ok", peak <= MAX_OUT, 1'b1);
    chk("err_end", err, cnt > DEPTH);
    if (drop) begin
      @(posedge clk); #2;
      chk("done_pulse_one_cycle", preload_done, 1'b0);
      chk("idle_after_pulse", busy, 1'b0);
    end else begin
      k = $urandom_range(1, 3);
      repeat (k) begin
        @(posedge clk); #2;
        chk("done_held", preload_done, 1'b1);
      end
      preload_req = 1'b0;
      @(posedge clk); #2;
      chk("done_drop", preload_done, 1'b0);
      chk("idle_after_drop", busy, 1'b0);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    salt = $urandom;
    preload_req = 1'b0; preload_base = '0; preload_count = '0;
    mem_rd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", preload_done, 1'b0);
    chk("rst_rd_req", mem_rd_req, 1'b0);
    chk("rst_buf_we", buf_we, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_addr", mem_rd_addr, '0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_xfer(19'h00100, 4, 2, 0, 0);
    run_xfer(ADDR_W'($urandom), 10, 8, 1, 0);
    run_xfer(ADDR_W'($urandom), 0, 2, 0, 0);
    run_xfer(19'h7FFFE, 4, 1, 0, 0);
    repeat (6) run_xfer(ADDR_W'($urandom), $urandom_range(1, 40), $urandom_range(1, 10), 2,
                        1'($urandom_range(0, 1)));
    run_xfer(ADDR_W'($urandom), 32769, 1, 0, 0);

    // Spurious response while idle.
    we_cnt = 0;
    spur = 1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("spurious_err", err, 1'b1);
    chk("spurious_no_write", we_cnt, 0);
    run_xfer(ADDR_W'($urandom), 3, 2, 0, 0);

    // Reset during DRAIN with two reads outstanding.
    lat = 8; rdy_mode = 0; peak = 0;
    push_expected(19'h01230, 10);
    preload_base = 19'h01230; preload_count = 17'd10; preload_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(exp_addr.size() == 0 && outst == 2) && n < 300);
    chk("reached_drain_two_out", outst, 2);
    hold_rsp = 1; rst_n = 1'b0; preload_req = 1'b0;
    #1;
    chk("mid_rst_buf_we", buf_we, 1'b0);
    chk("mid_rst_rd_req", mem_rd_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", preload_done, 1'b0);
    chk("mid_rst_buf_addr", buf_addr, '0);
    chk("mid_rst_buf_wdata", buf_wdata, '0);
    chk("mid_rst_rd_addr", mem_rd_addr, '0);
    exp_wr.delete(); exp_addr.delete(); outst = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; we_cnt = 0; hold_rsp = 0;
    repeat (12) @(posedge clk);
    #2;
    chk("late_rsp_no_write", we_cnt, 0);
    chk("late_rsp_no_err", err, 1'b0);
    run_xfer(ADDR_W'($urandom), 2, 3, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
